// File: rtl/cache_data_array_2p_pkg.sv
// Shared types and helpers for the two-port cache data array.
package cache_data_array_2p_pkg;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StReady = 1'b1
  } clr_state_e;

  function automatic int unsigned calc_num_wmasks(int unsigned data_width,
                                                  int unsigned mask_gran);
    return data_width / mask_gran;
  endfunction

endpackage

// File: rtl/cache_clear_seq.sv
// Zero-fill sweep sequencer: walks every address once after reset or a flush request.
module cache_clear_seq
  import cache_data_array_2p_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  clr,
  output logic                  ready,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = StReady;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      StReady: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready      = (state_q == StReady);
  assign clear_we   = (state_q == StClear);
  assign clear_addr = cnt_q;

endmodule

// File: rtl/cache_data_array_2p.sv
// Two-port (RW + R) cache data array with lane write mask, write-first collision
// forwarding to the read port, and a zero-fill sweep on reset or flush.
module cache_data_array_2p
  import cache_data_array_2p_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MASK_GRAN  = 8,
  localparam int unsigned NUM_WMASKS = calc_num_wmasks(DATA_WIDTH, MASK_GRAN)
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  clr,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  wr0, rd0, rd1;
  logic [DATA_WIDTH-1:0] merged0;
  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  cache_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .clr        (clr),
    .ready      (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  // Requests are only honoured once the sweep has finished.
  assign wr0 = ready & ~csb0 & ~web0;
  assign rd0 = ready & ~csb0 &  web0;
  assign rd1 = ready & ~csb1;

  always_comb begin
    merged0 = mem_q[addr0];
    for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) begin
        merged0[i*MASK_GRAN +: MASK_GRAN] = din0[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  always_comb begin
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    if (rd0) begin
      dout0_d = mem_q[addr0];
    end
    if (rd1) begin
      // Same-edge write to the same word is forwarded (write-first).
      dout1_d = (wr0 && (addr1 == addr0)) ? merged0 : mem_q[addr1];
    end
  end

  always_ff @(posedge clk0) begin
    if (clear_we) begin
      mem_q[clear_addr] <= '0;
    end else if (wr0) begin
      mem_q[addr0] <= merged0;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  assign dout0 = dout0_q;
  assign dout1 = dout1_q;

endmodule

// File: tb/tb_cache_data_array_2p.sv
// Scoreboard bench for cache_data_array_2p: directed reads push expected words,
// a monitor pops and compares them one cycle after each accepted read.
module tb_cache_data_array_2p;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 4;
  localparam int unsigned NM = 32;

  logic          clk0 = 1'b0;
  logic          rst0_n;
  logic          clr;
  logic          ready;
  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [NM-1:0] wmask0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  localparam logic [DW-1:0] A5S = {32{8'hA5}};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  cache_data_array_2p #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MASK_GRAN  (8)
  ) dut (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .clr    (clr),
    .ready  (ready),
    .csb0   (csb0),
    .web0   (web0),
    .addr0  (addr0),
    .wmask0 (wmask0),
    .din0   (din0),
    .dout0  (dout0),
    .csb1   (csb1),
    .addr1  (addr1),
    .dout1  (dout1)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read accepted at an edge must show its word just after that edge.
  always begin
    logic r0, r1;
    @(posedge clk0);
    r0 = rst0_n && ready && !csb0 && web0;
    r1 = rst0_n && ready && !csb1;
    #1;
    if (r0) begin
      if (q0.size() == 0) begin
        errors++; checks++;
        $display("FAIL port0_unexpected_read: got %h expected none", dout0);
      end else begin
        check("port0_read", dout0, q0.pop_front());
      end
    end
    if (r1) begin
      if (q1.size() == 0) begin
        errors++; checks++;
        $display("FAIL port1_unexpected_read: got %h expected none", dout1);
      end else begin
        check("port1_read", dout1, q1.pop_front());
      end
    end
  end

  task automatic idle();
    @(negedge clk0);
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; clr = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [NM-1:0] m, input logic [DW-1:0] d);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; wmask0 = m; din0 = d; csb1 = 1'b1; clr = 1'b0;
  endtask

  task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] e);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; csb1 = 1'b1; clr = 1'b0;
    q0.push_back(e);
  endtask

  task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] e);
    @(negedge clk0);
    csb0 = 1'b1; csb1 = 1'b0; addr1 = a; clr = 1'b0;
    q1.push_back(e);
  endtask

  task automatic rd_both(input logic [AW-1:0] a, input logic [DW-1:0] e0,
                         input logic [DW-1:0] e1);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; csb1 = 1'b0; addr1 = a; clr = 1'b0;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic wr0_rd1(input logic [AW-1:0] a, input logic [NM-1:0] m,
                         input logic [DW-1:0] d, input logic [DW-1:0] e1);
    @(negedge clk0);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; wmask0 = m; din0 = d;
    csb1 = 1'b0; addr1 = a; clr = 1'b0;
    q1.push_back(e1);
  endtask

  // Counts edges until ready; requests still asserted are dropped after 10 edges.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk0);
      #1;
      n++;
      if (n == 10) begin
        csb0 = 1'b1; csb1 = 1'b1;
      end
    end
  endtask

  task automatic clr_pulse();
    @(negedge clk0);
    csb0 = 1'b1; csb1 = 1'b1; clr = 1'b1;
    @(posedge clk0);
    #1;
    clr = 1'b0;
    check("ready_low_after_clr", DW'(ready), '0);
  endtask

  initial begin
    int n;
    rst0_n = 1'b0; clr = 1'b0; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    addr0 = '0; addr1 = '0; wmask0 = '0; din0 = '0;
    repeat (3) @(posedge clk0);
    #1;
    check("reset_ready", DW'(ready), '0);
    check("reset_dout0", dout0, '0);
    check("reset_dout1", dout1, '0);

    // Illegal request held during the sweep must be ignored.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; wmask0 = '1; din0 = DW'(1);
    csb1 = 1'b0; addr1 = 4'd2;
    @(negedge clk0);
    rst0_n = 1'b1;
    wait_ready(n);
    check("sweep_latency_reset", DW'(n), DW'(16));
    check("dout0_hold_in_clear", dout0, '0);
    check("dout1_hold_in_clear", dout1, '0);

    for (int a = 0; a < 16; a++) rd_both(AW'(a), '0, '0);

    wr0(4'd3, 32'h0000_000F, {{7{32'hFFFF_FFFF}}, 32'hDEADBEEF});
    rd0(4'd3, DW'(32'hDEADBEEF));
    wr0(4'd3, 32'h0000_0030, {32{8'h11}});
    @(posedge clk0);
    #1;
    check("dout0_hold_on_write", dout0, DW'(32'hDEADBEEF));
    rd0(4'd3, DW'(48'h1111_DEADBEEF));
    wr0(4'd3, 32'h0, ONES);
    rd0(4'd3, DW'(48'h1111_DEADBEEF));

    wr0_rd1(4'd5, '1, A5S, A5S);
    rd1(4'd5, A5S);
    wr0_rd1(4'd3, 32'h1, {32{8'h77}}, DW'(48'h1111_DEADBE77));
    idle();
    rd0(4'd5, A5S);
    idle();
    @(posedge clk0);
    #1;
    check("dout1_hold_csb", dout1, DW'(48'h1111_DEADBE77));
    check("dout0_hold_csb", dout0, A5S);

    wr0(4'd7, '1, DW'(1));
    rd0(4'd7, DW'(1));
    clr_pulse();
    repeat (5) @(posedge clk0);
    clr_pulse();
    wait_ready(n);
    check("sweep_latency_clr_restart", DW'(n), DW'(16));
    rd_both(4'd7, '0, '0);
    rd_both(4'd3, '0, '0);

    wr0(4'd9, '1, DW'(8'h55));
    rd_both(4'd9, DW'(8'h55), DW'(8'h55));
    clr_pulse();
    repeat (8) @(posedge clk0);
    #2;
    rst0_n = 1'b0;
    #1;
    check("async_reset_dout0", dout0, '0);
    check("async_reset_dout1", dout1, '0);
    check("async_reset_ready", DW'(ready), '0);
    @(negedge clk0);
    rst0_n = 1'b1;
    wait_ready(n);
    check("sweep_latency_midreset", DW'(n), DW'(16));
    rd_both(4'd9, '0, '0);
    rd0(4'd15, '0);

    idle();
    repeat (3) @(posedge clk0);
    #2;
    check("scoreboard_q0_drained", DW'(q0.size()), '0);
    check("scoreboard_q1_drained", DW'(q1.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_data_array_2p.md
CACHE_DATA_ARRAY_2P -- requirements
Module: cache_data_array_2p

Interface
REQ-001 Parameter: DATA_WIDTH, default 256, bits per word.
REQ-002 Parameter: ADDR_WIDTH, default 4, address bits; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter: MASK_GRAN, default 8, bits per write-mask lane; DATA_WIDTH SHALL be a multiple of MASK_GRAN; NUM_WMASKS = DATA_WIDTH/MASK_GRAN.
REQ-004 clk0  input  1  the only clock; all state updates on its rising edge.
REQ-005 rst0_n  input  1  reset, asynchronous assert, active-low.
REQ-006 clr  input  1  pulse: re-run the zero-fill sweep (cache flush).
REQ-007 ready  output  1  high when the array accepts requests.
REQ-008 csb0  input  1  port 0 (RW) active-low chip select.
REQ-009 web0  input  1  port 0 active-low write enable.
REQ-010 addr0  input  ADDR_WIDTH  port 0 address.
REQ-011 wmask0  input  NUM_WMASKS  port 0 lane write mask, 1 = write lane.
REQ-012 din0  input  DATA_WIDTH  port 0 write data.
REQ-013 dout0  output  DATA_WIDTH  port 0 read data, registered.
REQ-014 csb1  input  1  port 1 (R only) active-low chip select.
REQ-015 addr1  input  ADDR_WIDTH  port 1 address.
REQ-016 dout1  output  DATA_WIDTH  port 1 read data, registered.

Function
REQ-017 FSM states: CLEAR, READY; ready SHALL be 1 only in READY.
REQ-018 CLEAR: 1 word per cycle, counter 0..DEPTH-1, writes all-zero data; after writing DEPTH-1 the next state is READY; the sweep takes exactly DEPTH cycles.
REQ-019 clr sampled high in READY -> CLEAR with counter = 0 next cycle; clr in CLEAR restarts the counter at 0.
REQ-020 While ready=0, csb0/csb1 SHALL be ignored: no write, dout0/dout1 hold.
REQ-021 Port 0 write (ready, csb0=0, web0=0): at the edge, each lane i with wmask0[i]=1 takes din0 lane i; other lanes unchanged; dout0 holds its previous value.
REQ-022 Port 0 read (ready, csb0=0, web0=1): dout0 = mem[addr0] registered at the same edge (1-cycle latency).
REQ-023 Port 1 read (ready, csb1=0): dout1 = mem[addr1] registered at the same edge.
REQ-024 Collision: port 0 write and port 1 read to the same address on the same edge -> dout1 SHALL return write-first data (masked lanes from din0, others from old word).
REQ-025 csb high on a port: that port's dout holds.
REQ-026 wmask0 all-zero write: no memory change, still a legal cycle.

Reset
REQ-027 rst0_n low: asynchronously state = CLEAR, counter = 0, ready = 0, dout0 = 0, dout1 = 0.
REQ-028 After rst0_n rises, the sweep runs automatically; ready rises DEPTH cycles later.
REQ-029 Reset mid-sweep or mid-operation restarts the sweep from address 0; memory contents need no asynchronous reset.

Structure
REQ-030 Shared package: state enum (CLEAR, READY) and a helper constant for NUM_WMASKS derivation.
REQ-031 One sub-module: cache_clear_seq (FSM + counter, outputs ready, clear_we, clear_addr); storage and port logic stay in the parent.

Verification (DATA_WIDTH=256, ADDR_WIDTH=4, MASK_GRAN=8)
REQ-032 Release rst0_n -> ready=0 for 16 cycles, then 1; reads of addr 0..15 on both ports return 0.
REQ-033 Write addr 3, wmask0=32'h0000_000F, din0 lanes 0-3 = 32'hDEADBEEF -> a port-0 read of addr 3 one cycle later returns 256'h...0000_DEADBEEF.
REQ-034 Port 0 writes addr 5 full mask 256'hA5..A5 while port 1 reads addr 5 on the same edge -> dout1 = 256'hA5..A5.
REQ-035 Write addr 7 = 256'h1, pulse clr -> ready=0 for 16 cycles; afterwards a read of addr 7 returns 0.
REQ-036 Assert rst0_n low at sweep count 8 -> dout0/dout1=0 immediately; the sweep restarts and ready rises 16 cycles after release.
REQ-037 Request issued with ready=0 (csb0=0, web0=0, addr 2, data 1) -> no effect; addr 2 reads 0 after READY.
